// File: rtl/x9_branch_pkg.sv
// Shared types for the branch resolve unit: condition encodings, FSM states
// and the width of the optional statistics counters.
package x9_branch_pkg;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_IF_SET = 2'b01,
    BR_IF_CLR = 2'b10,
    BR_RSVD   = 2'b11
  } br_cond_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_REDIR = 1'b1
  } br_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/branch_target_lut.sv
// Branch-target register file: async read with write-first bypass,
// cleared by the asynchronous active-low reset.
module branch_target_lut
  import x9_branch_pkg::*;
#(
  parameter int A     = 8,
  parameter int LUT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [LUT_W-1:0] waddr,
  input  logic [A-1:0]     wdata,
  input  logic [LUT_W-1:0] raddr,
  output logic [A-1:0]     rdata
);

  logic [A-1:0] mem [2**LUT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**LUT_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to the entry being read wins over the stored value
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves decoded branches into a registered one-cycle fetch redirect and
// squashes the sequential shadow. Optional counters under BRANCH_STATS_EN.
module branch_resolve_unit
  import x9_branch_pkg::*;
#(
  parameter int A     = 8,
  parameter int LUT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inst_valid,
  input  logic             is_br,
  input  logic [1:0]       br_cond,
  input  logic [LUT_W-1:0] br_idx,
  input  logic             flag_we,
  input  logic             flag_in,
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_waddr,
  input  logic [A-1:0]     lut_wdata,
  input  logic             halt,
  output logic             ctrl_branch,
  output logic             take_branch,
  output logic [A-1:0]     inst_addr_in,
  output logic             squash
`ifdef BRANCH_STATS_EN
  ,
  output logic [STATS_W-1:0] taken_cnt,
  output logic [STATS_W-1:0] not_taken_cnt
`endif
);

  br_state_t    state;
  logic         flag_q;
  logic         flag_eff;
  logic         accept;
  logic         taken;
  logic [A-1:0] target;

  branch_target_lut #(.A(A), .LUT_W(LUT_W)) u_lut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (lut_we),
    .waddr   (lut_waddr),
    .wdata   (lut_wdata),
    .raddr   (br_idx),
    .rdata   (target)
  );

  assign squash   = (state == S_REDIR) && take_branch;
  assign accept   = inst_valid && is_br && !halt && !squash;
  assign flag_eff = flag_we ? flag_in : flag_q;

  always_comb begin
    taken = 1'b0;
    case (br_cond_t'(br_cond))
      BR_ALWAYS: taken = 1'b1;
      BR_IF_SET: taken = flag_eff;
      BR_IF_CLR: taken = !flag_eff;
      default:   taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
    end else if (flag_we) begin
      flag_q <= flag_in;
    end
  end

  // Redirect FSM: an accepted branch always lands in S_REDIR for the next
  // cycle; anything else (including a squashed shadow) falls back to S_RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RUN;
      ctrl_branch  <= 1'b0;
      take_branch  <= 1'b0;
      inst_addr_in <= '0;
    end else if (accept) begin
      state        <= S_REDIR;
      ctrl_branch  <= 1'b1;
      take_branch  <= taken;
      inst_addr_in <= target;
    end else begin
      state        <= S_RUN;
      ctrl_branch  <= 1'b0;
      take_branch  <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (accept) begin
      if (taken) taken_cnt     <= sat_inc(taken_cnt);
      else       not_taken_cnt <= sat_inc(not_taken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table with an expected
// output queue, plus hand sequences for reset-mid-redirect and stats.
module tb_branch_resolve_unit;

  localparam int A     = 8;
  localparam int LUT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             inst_valid, is_br, flag_we, flag_in, lut_we, halt;
  logic [1:0]       br_cond;
  logic [LUT_W-1:0] br_idx, lut_waddr;
  logic [A-1:0]     lut_wdata;
  logic             ctrl_branch, take_branch, squash;
  logic [A-1:0]     inst_addr_in;
`ifdef BRANCH_STATS_EN
  logic [15:0]      taken_cnt, not_taken_cnt;
`endif

  branch_resolve_unit #(.A(A), .LUT_W(LUT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inst_valid   (inst_valid),
    .is_br        (is_br),
    .br_cond      (br_cond),
    .br_idx       (br_idx),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .halt         (halt),
    .ctrl_branch  (ctrl_branch),
    .take_branch  (take_branch),
    .inst_addr_in (inst_addr_in),
    .squash       (squash)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .not_taken_cnt(not_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic [1:0] cond;
    logic [3:0] idx;
    logic       fwe;
    logic       fin;
    logic       lwe;
    logic [3:0] lwa;
    logic [7:0] lwd;
    logic       hlt;
    logic       e_ctrl;
    logic       e_take;
    logic [7:0] e_addr;
    logic       e_sq;
  } vec_t;

  typedef struct {
    logic       ctrl;
    logic       take;
    logic [7:0] addr;
    logic       sq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   exp_taken = 0;
  int   exp_not_taken = 0;

  function automatic vec_t mk(logic br, logic [1:0] cond, logic [3:0] idx,
                              logic fwe, logic fin, logic lwe, logic [3:0] lwa,
                              logic [7:0] lwd, logic hlt, logic e_ctrl,
                              logic e_take, logic [7:0] e_addr, logic e_sq);
    vec_t v;
    v.br = br; v.cond = cond; v.idx = idx; v.fwe = fwe; v.fin = fin;
    v.lwe = lwe; v.lwa = lwa; v.lwd = lwd; v.hlt = hlt;
    v.e_ctrl = e_ctrl; v.e_take = e_take; v.e_addr = e_addr; v.e_sq = e_sq;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_valid = 0; is_br = 0; br_cond = 0; br_idx = 0; flag_we = 0;
    flag_in = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0; halt = 0;
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    inst_valid = v.br; is_br = v.br; br_cond = v.cond; br_idx = v.idx;
    flag_we = v.fwe; flag_in = v.fin; lut_we = v.lwe; lut_waddr = v.lwa;
    lut_wdata = v.lwd; halt = v.hlt;
    e.ctrl = v.e_ctrl; e.take = v.e_take; e.addr = v.e_addr; e.sq = v.e_sq;
    sb.push_back(e);
    if (v.e_ctrl && v.e_take) exp_taken++;
    if (v.e_ctrl && !v.e_take) exp_not_taken++;
  endtask

  task automatic check_out(int n);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_ctrl", n), ctrl_branch, e.ctrl);
    chk($sformatf("v%0d_take", n), take_branch, e.take);
    chk($sformatf("v%0d_addr", n), inst_addr_in, e.addr);
    chk($sformatf("v%0d_squash", n), squash, e.sq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // br cond idx fwe fin lwe lwa lwd hlt | ctrl take addr sq
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1, 2, 8'h40, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1, 4, 8'h55, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h40, 1)); // taken
    vecs.push_back(mk(1, 2'b00, 4, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h40, 0)); // shadow ignored
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h40, 0));
    vecs.push_back(mk(1, 2'b01, 4, 1, 1, 0, 0, 8'h00, 0, 1, 1, 8'h55, 1)); // flag bypass
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0)); // flag=0
    vecs.push_back(mk(1, 2'b10, 2, 1, 1, 0, 0, 8'h00, 0, 1, 0, 8'h40, 0)); // bypass, not taken
    vecs.push_back(mk(1, 2'b00, 4, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h55, 1)); // back-to-back
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0));
    vecs.push_back(mk(1, 2'b10, 2, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 0)); // reg flag=1
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h40, 0));
    vecs.push_back(mk(1, 2'b00, 5, 0, 0, 1, 5, 8'h7F, 0, 1, 1, 8'h7F, 1)); // write-first
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h7F, 0));
    vecs.push_back(mk(1, 2'b11, 4, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h55, 0)); // reserved
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h55, 0)); // halted
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h55, 0));
    vecs.push_back(mk(1, 2'b01, 2, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h40, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h40, 0));
    vecs.push_back(mk(1, 2'b00, 4, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h55, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h55, 0)); // halt in redirect

    idle_inputs();
    reset_n = 1'b0;
    #12;
    chk("reset_ctrl", ctrl_branch, 0);
    chk("reset_take", take_branch, 0);
    chk("reset_addr", inst_addr_in, 0);
    chk("reset_squash", squash, 0);
`ifdef BRANCH_STATS_EN
    chk("reset_taken_cnt", taken_cnt, 0);
    chk("reset_not_taken_cnt", not_taken_cnt, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check_out(i);
    end

`ifdef BRANCH_STATS_EN
    chk("taken_cnt", taken_cnt, exp_taken);
    chk("not_taken_cnt", not_taken_cnt, exp_not_taken);
`endif

    // Reset asserted while a taken redirect is being presented
    idle_inputs();
    lut_we = 1; lut_waddr = 3; lut_wdata = 8'h33;
    inst_valid = 1; is_br = 1; br_cond = 2'b00; br_idx = 3;
    @(posedge clk); #1;
    idle_inputs();
    chk("pre_reset_ctrl", ctrl_branch, 1);
    chk("pre_reset_addr", inst_addr_in, 8'h33);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", ctrl_branch, 0);
    chk("midreset_take", take_branch, 0);
    chk("midreset_addr", inst_addr_in, 0);
    chk("midreset_squash", squash, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // LUT[3] was cleared; flag was cleared so cond 01 is not taken
    @(posedge clk); #1;
    inst_valid = 1; is_br = 1; br_cond = 2'b01; br_idx = 3;
    @(posedge clk); #1;
    idle_inputs();
    chk("post_reset_ctrl", ctrl_branch, 1);
    chk("post_reset_take", take_branch, 0);
    chk("post_reset_lut3", inst_addr_in, 8'h00);
    @(posedge clk); #1;
    chk("post_reset_return", ctrl_branch, 0);
`ifdef BRANCH_STATS_EN
    chk("post_reset_not_taken_cnt", not_taken_cnt, 1);
    chk("post_reset_taken_cnt", taken_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Other end of the fetch-redirect interface. Consumes decoded instructions and drives ctrl_branch / take_branch / inst_addr_in into the fetch stage.
- Holds the condition flag register and a loadable branch-target LUT, since the 9-bit ISA carries a LUT index rather than a full target.
- Registers the redirect for one cycle and squashes the single sequential-shadow instruction after a taken branch.

Parameters:
- A, 8, instruction address width; must match the fetch stage.
- LUT_W, 4, branch-target LUT index width (2**LUT_W entries).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  decoded instruction present this cycle.
- is_br  in  1  decoded instruction is a branch.
- br_cond  in  2  00 always, 01 if flag, 10 if !flag, 11 reserved.
- br_idx  in  LUT_W  LUT index of the branch target.
- flag_we  in  1  flag write strobe from execute.
- flag_in  in  1  new flag value.
- lut_we  in  1  LUT write strobe.
- lut_waddr  in  LUT_W  LUT write index.
- lut_wdata  in  A  LUT write data (absolute target).
- halt  in  1  fetch stage halted.
- ctrl_branch  out  1  redirect request valid (to fetch).
- take_branch  out  1  branch resolved taken (to fetch).
- inst_addr_in  out  A  redirect target (to fetch).
- squash  out  1  current decoded instruction is a shadow and must be killed.

Behaviour:
- Reset (reset_n=0, async):
  - State S_RUN.
  - ctrl_branch=0, take_branch=0, inst_addr_in=0, squash=0.
  - Flag register = 0; all LUT entries = 0.
- Acceptance: a branch is accepted when inst_valid && is_br && !halt && !squash.
- Condition evaluation uses the effective flag: flag_in if flag_we is high in the same cycle (bypass), else the flag register.
  - cond 00: always taken.
  - cond 01: taken if flag = 1.
  - cond 10: taken if flag = 0.
  - cond 11: never taken, but ctrl_branch is still asserted.
- Target read uses effective LUT data. Write-first: if lut_we && lut_waddr == br_idx in the same cycle, the target is lut_wdata.
- State machine:
  - S_RUN: on an accepted branch, register ctrl_branch=1, take_branch=taken, inst_addr_in=target for the next cycle. Go to S_REDIR.
  - S_REDIR (exactly one cycle, outputs high):
    - If take_branch=1, squash=1 combinationally. The instruction decoded this cycle is the sequential shadow and is ignored, even if it is a branch. Its flag_we and lut_we are still honoured; the upstream kill gates them.
    - If take_branch=0, squash=0 and a branch in this cycle is accepted (back-to-back). Stay in S_REDIR with new outputs.
    - Otherwise return to S_RUN with ctrl_branch=0 and take_branch=0.
  - inst_addr_in holds its last value when ctrl_branch=0.
- Latency: branch decode cycle N; redirect visible cycle N+1; fetch loads target at end of N+1.
- Halt: while halt=1 no branch is accepted. A redirect already in S_REDIR completes.
- Flag and LUT writes occur every cycle their strobe is high, independent of state.
- Reset asserted mid-redirect: outputs drop immediately (async); no residual squash.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs taken_cnt[15:0] and not_taken_cnt[15:0].
  - Each increments on the posedge at which a resolved redirect (including cond 11) is registered, i.e. on the posedge that latches ctrl_branch=1.
  - Counters saturate at 16'hFFFF; reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package x9_branch_pkg:
  - br_cond_t enum: BR_ALWAYS, BR_IF_SET, BR_IF_CLR, BR_RSVD.
  - br_state_t enum: S_RUN, S_REDIR.
  - Stats counter width constant.
- Sub-module branch_target_lut: 2**LUT_W x A register file with async read, write-first bypass, and async active-low clear.

Test Plan:
- Reset check: reset_n low mid-S_REDIR with ctrl_branch=1 -> all outputs 0 immediately; LUT[3] reads 0 after release.
- Taken branch: LUT[2]=8'h40, cond 00, idx 2 at cycle N -> cycle N+1 ctrl_branch=1, take_branch=1, inst_addr_in=8'h40, squash=1; shadow branch at N+1 ignored; cycle N+2 ctrl_branch=0.
- Flag bypass: flag reg=0, flag_we=1, flag_in=1 in the same cycle as a cond 01 branch -> take_branch=1. Same setup with cond 10 -> take_branch=0, squash=0.
- Back-to-back not-taken: cond 10 with flag=1, then a cond 00 branch next cycle -> two consecutive ctrl_branch cycles; second has take_branch=1 and target LUT[idx].
- LUT write-first and reserved cond: lut_we at idx 5 with 8'h7F while branching on idx 5 -> inst_addr_in=8'h7F. Cond 11 -> ctrl_branch=1, take_branch=0.
- Halt and stats (BRANCH_STATS_EN): halt=1 with a valid branch -> no ctrl_branch. With stats enabled, 3 taken and 2 not-taken branches -> taken_cnt=3, not_taken_cnt=2.
